// File: rtl/lzc_arbiter.sv
// Round-robin arbiter sharing one 16-bit leading-zero counter between two renorm requesters.
// Optional grant statistics counters are enabled with `define LZC_ARB_STATS_EN.
module lzc_arbiter #(
    parameter int unsigned RANGE_WIDTH = 16,
    parameter int unsigned D_SIZE      = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [RANGE_WIDTH-1:0] req0_range,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [RANGE_WIDTH-1:0] req1_range,
    output logic                   req1_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_id,
    output logic [D_SIZE-1:0]      res_count,
    output logic [RANGE_WIDTH-1:0] res_norm_range,
    output logic                   res_zero
`ifdef LZC_ARB_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [15:0]            stat_grants0,
    output logic [15:0]            stat_grants1
`endif
);

    localparam int unsigned STAT_WIDTH = 16;

    typedef struct packed {
        logic                   id;
        logic [D_SIZE-1:0]      count;
        logic [RANGE_WIDTH-1:0] norm;
        logic                   zero;
    } res_t;

    res_t                   res_q, res_d;
    logic                   res_valid_q, res_valid_d;
    logic                   last_grant_q, last_grant_d;
    logic                   accept;
    logic                   grant0, grant1, grant;
    logic [RANGE_WIDTH-1:0] sel_range;
    logic [RANGE_WIDTH-1:0] lz_x;
    logic                   lzc_v;
    logic [D_SIZE-1:0]      lzc_out;
    logic [D_SIZE-1:0]      count;

    // Round-robin grant; only one requester can be selected, so an idle requester's X data never reaches the mux output.
    always_comb begin
        accept = reset & (~res_valid_q | res_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        grant = grant0 | grant1;
        if (grant1) begin
            sel_range = req1_range;
        end else if (grant0) begin
            sel_range = req0_range;
        end else begin
            sel_range = '0;
        end
    end

    // Leading-zero count by binary search over halves of the 16-bit operand.
    always_comb begin : leading_zero
        lz_x    = sel_range;
        lzc_out = '0;
        lzc_v   = |sel_range;
        if (lz_x[RANGE_WIDTH-1 -: 8] == 8'd0) begin
            lzc_out[3] = 1'b1;
            lz_x       = lz_x << 8;
        end
        if (lz_x[RANGE_WIDTH-1 -: 4] == 4'd0) begin
            lzc_out[2] = 1'b1;
            lz_x       = lz_x << 4;
        end
        if (lz_x[RANGE_WIDTH-1 -: 2] == 2'd0) begin
            lzc_out[1] = 1'b1;
            lz_x       = lz_x << 2;
        end
        if (!lz_x[RANGE_WIDTH-1]) begin
            lzc_out[0] = 1'b1;
        end
    end

    always_comb begin
        count        = lzc_v ? lzc_out : D_SIZE'(RANGE_WIDTH);
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            res_valid_d  = 1'b1;
            res_d.id     = grant1;
            res_d.count  = count;
            res_d.norm   = sel_range << count;
            res_d.zero   = ~lzc_v;
            last_grant_d = grant1;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready     = grant0;
    assign req1_ready     = grant1;
    assign res_valid      = res_valid_q;
    assign res_id         = res_q.id;
    assign res_count      = res_q.count;
    assign res_norm_range = res_q.norm;
    assign res_zero       = res_q.zero;

`ifdef LZC_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat0_q, stat0_d;
    logic [STAT_WIDTH-1:0] stat1_q, stat1_d;

    // Saturating per-requester grant counters; clear wins over increment.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (stat_clr) begin
            stat0_d = '0;
            stat1_d = '0;
        end else begin
            if (grant0 && (stat0_q != '1)) stat0_d = stat0_q + STAT_WIDTH'(1);
            if (grant1 && (stat1_q != '1)) stat1_d = stat1_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_grants0 = stat0_q;
    assign stat_grants1 = stat1_q;
`endif

endmodule

// File: tb/tb_lzc_arbiter.sv
// Randomized self-checking bench for lzc_arbiter against a behavioural reference model.
module tb_lzc_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_range = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_range = '0;
    logic        req1_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_id;
    logic [4:0]  res_count;
    logic [15:0] res_norm_range;
    logic        res_zero;
`ifdef LZC_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_grants0;
    logic [15:0] stat_grants1;
`endif

    int vectors = 0;
    int errors  = 0;

    lzc_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_range     (req0_range),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_range     (req1_range),
        .req1_ready     (req1_ready),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_id         (res_id),
        .res_count      (res_count),
        .res_norm_range (res_norm_range),
        .res_zero       (res_zero)
`ifdef LZC_ARB_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_grants0   (stat_grants0),
        .stat_grants1   (stat_grants1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: the single result slot plus the last winner.
    bit          m_valid = 1'b0;
    bit          m_id    = 1'b0;
    int          m_count = 0;
    logic [15:0] m_norm  = '0;
    bit          m_zero  = 1'b0;
    bit          m_last  = 1'b1;
    int          m_stat0 = 0;
    int          m_stat1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lz(input logic [15:0] x);
        return 16 - $clog2(32'(x) + 1);
    endfunction

    function automatic void exp_ready(output bit r0, output bit r1);
        r0 = 1'b0;
        r1 = 1'b0;
        if (reset && (!m_valid || res_ready)) begin
            if (req0_valid && req1_valid) begin
                if (m_last == 1'b1) r0 = 1'b1;
                else                r1 = 1'b1;
            end else begin
                r0 = req0_valid;
                r1 = req1_valid;
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin : model_upd
        bit          r0, r1;
        logic [15:0] x;
        int          c;
        if (!reset) begin
            m_valid <= 1'b0;
            m_id    <= 1'b0;
            m_count <= 0;
            m_norm  <= '0;
            m_zero  <= 1'b0;
            m_last  <= 1'b1;
            m_stat0 <= 0;
            m_stat1 <= 0;
        end else begin
            exp_ready(r0, r1);
            if (r0 || r1) begin
                x = r1 ? req1_range : req0_range;
                c = lz(x);
                m_valid <= 1'b1;
                m_id    <= r1;
                m_count <= c;
                m_norm  <= 16'(32'(x) * (32'd1 << c));
                m_zero  <= (x == 16'd0);
                m_last  <= r1;
            end else if (res_ready) begin
                m_valid <= 1'b0;
            end
`ifdef LZC_ARB_STATS_EN
            if (stat_clr) begin
                m_stat0 <= 0;
                m_stat1 <= 0;
            end else begin
                if (r0 && m_stat0 < 65535) m_stat0 <= m_stat0 + 1;
                if (r1 && m_stat1 < 65535) m_stat1 <= m_stat1 + 1;
            end
`endif
        end
    end

    always @(negedge clk) begin : compare
        bit r0, r1;
        exp_ready(r0, r1);
        check("req0_ready", 32'(req0_ready), 32'(r0));
        check("req1_ready", 32'(req1_ready), 32'(r1));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid) begin
            check("res_id", 32'(res_id), 32'(m_id));
            check("res_count", 32'(res_count), 32'(m_count));
            check("res_norm_range", 32'(res_norm_range), 32'(m_norm));
            check("res_zero", 32'(res_zero), 32'(m_zero));
        end
`ifdef LZC_ARB_STATS_EN
        check("stat_grants0", 32'(stat_grants0), 32'(m_stat0));
        check("stat_grants1", 32'(stat_grants1), 32'(m_stat1));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_range();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom) >> $urandom_range(0, 15);
        endcase
    endfunction

    initial begin
        repeat (2) step();
        reset = 1'b1;

        // Single request: 0x0100 has 7 leading zeros.
        req0_valid = 1'b1;
        req0_range = 16'h0100;
        res_ready  = 1'b1;
        step();
        check("t1_valid", 32'(res_valid), 1);
        check("t1_id", 32'(res_id), 0);
        check("t1_count", 32'(res_count), 7);
        check("t1_norm", 32'(res_norm_range), 32'h8000);
        check("t1_zero", 32'(res_zero), 0);
        req0_valid = 1'b0;

        // Reset pulse so the dual-request run starts with requester 0 priority.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        req0_valid = 1'b1;
        req0_range = 16'h8000;
        req1_valid = 1'b1;
        req1_range = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t2_id", 32'(res_id), 32'(i % 2));
            check("t2_count", 32'(res_count), (i % 2 == 1) ? 15 : 0);
            check("t2_norm", 32'(res_norm_range), 32'h8000);
        end

        // All-zero operand from requester 1.
        req0_valid = 1'b0;
        req1_range = 16'h0000;
        step();
        check("t3_id", 32'(res_id), 1);
        check("t3_count", 32'(res_count), 16);
        check("t3_norm", 32'(res_norm_range), 0);
        check("t3_zero", 32'(res_zero), 1);

        // Stall with both valid, then drain and regrant in the same cycle.
        req0_valid = 1'b1;
        req0_range = 16'h0F00;
        req1_valid = 1'b1;
        req1_range = 16'h0003;
        step();
        check("t4_id", 32'(res_id), 0);
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_r0", 32'(req0_ready), 0);
            check("t4_stall_r1", 32'(req1_ready), 0);
            check("t4_stall_id", 32'(res_id), 0);
            check("t4_stall_count", 32'(res_count), 4);
            check("t4_stall_norm", 32'(res_norm_range), 32'hF000);
        end
        res_ready = 1'b1;
        #1;
        check("t4_drain_r1", 32'(req1_ready), 1);
        check("t4_drain_r0", 32'(req0_ready), 0);
        step();
        check("t4_valid", 32'(res_valid), 1);
        check("t4_id2", 32'(res_id), 1);
        check("t4_count2", 32'(res_count), 14);
        check("t4_norm2", 32'(res_norm_range), 32'hC000);

        // Asynchronous reset mid-cycle drops the pending result.
        #2;
        reset = 1'b0;
        #1;
        check("t5_valid_rst", 32'(res_valid), 0);
        check("t5_r0_rst", 32'(req0_ready), 0);
        check("t5_r1_rst", 32'(req1_ready), 0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t5_valid", 32'(res_valid), 1);
        check("t5_id", 32'(res_id), 0);

        // Randomized traffic with backpressure, idle X operands and occasional reset glitches.
        for (int i = 0; i < 4000; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_range = req0_valid ? rnd_range() : 16'hxxxx;
            req1_range = req1_valid ? rnd_range() : 16'hxxxx;
            res_ready  = ($urandom_range(0, 9) < 7);
`ifdef LZC_ARB_STATS_EN
            stat_clr   = ($urandom_range(0, 49) == 0);
`endif
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
            step();
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
